// File: rtl/pipe_flush_ctrl_if.sv
// pipe_flush_ctrl_if
// Bundles the hazard-event inputs and the flush/stall/PC-select outputs of
// the pipeline flush controller.
//   jump, br_taken, exc_req, load_use, mem_busy : hazard events (pipeline -> controller)
//   flush, stall       [STAGES-2:0]             : per-pipeline-register clear / hold
//   pc_stall, pc_sel   [1:0]                    : PC hold and PC mux select
//   drain_busy                                  : redirect drain in progress
//   redirect_cnt, bubble_cnt [15:0]             : event statistics
// Modports: master = pipeline side (drives events), slave = flush controller.
interface pipe_flush_ctrl_if #(
    parameter int STAGES = 5
);
    logic              jump;
    logic              br_taken;
    logic              exc_req;
    logic              load_use;
    logic              mem_busy;
    logic [STAGES-2:0] flush;
    logic [STAGES-2:0] stall;
    logic              pc_stall;
    logic [1:0]        pc_sel;
    logic              drain_busy;
    logic [15:0]       redirect_cnt;
    logic [15:0]       bubble_cnt;

    modport master (
        output jump, br_taken, exc_req, load_use, mem_busy,
        input  flush, stall, pc_stall, pc_sel, drain_busy, redirect_cnt, bubble_cnt
    );

    modport slave (
        input  jump, br_taken, exc_req, load_use, mem_busy,
        output flush, stall, pc_stall, pc_sel, drain_busy, redirect_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl
// Control-hazard and flush controller for the MIPS pipeline. Generates the
// per-pipeline-register flush and stall vectors and the PC redirect select
// for jump, taken branch, exception and load-use events, with an optional
// multi-cycle fetch drain after a redirect and a whole-pipe freeze while
// memory is busy.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_flush_ctrl_if.slave (events in; flush, stall, pc_stall,
//            pc_sel, drain_busy, redirect_cnt, bubble_cnt out)
// Optional feature macro: FLUSH_STATS_EN enables the saturating
// redirect_cnt / bubble_cnt counters; otherwise both read 0.
module pipe_flush_ctrl #(
    parameter int STAGES       = 5,
    parameter int J_STAGE      = 1,
    parameter int BR_STAGE     = 2,
    parameter int EXC_STAGE    = 3,
    parameter int REDIRECT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_flush_ctrl_if.slave bus
);

    localparam int NR = STAGES - 1;
    localparam int DW = (REDIRECT_LAT > 0) ? $clog2(REDIRECT_LAT + 1) : 1;

    localparam logic [DW-1:0] LAT_LOAD   = DW'(REDIRECT_LAT);
    localparam logic [NR-1:0] EXC_MASK   = NR'((1 << (EXC_STAGE + 1)) - 1);
    localparam logic [NR-1:0] BR_MASK    = NR'((1 << BR_STAGE) - 1);
    localparam logic [NR-1:0] J_MASK     = NR'((1 << J_STAGE) - 1);
    localparam logic [NR-1:0] BUBBLE_BIT = NR'(1 << J_STAGE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_JUMP = 2'd1;
    localparam logic [1:0] SEL_BR   = 2'd2;
    localparam logic [1:0] SEL_EXC  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [NR-1:0] flush_c, stall_c;
    logic          pc_stall_c;
    logic [1:0]    pc_sel_c;
    logic          drain_step;
    logic          freeze;

    // Outputs are a pure function of this cycle's events plus the drain
    // counter, so a redirect acts with zero latency.
    always_comb begin
        flush_c    = '0;
        stall_c    = '0;
        pc_stall_c = 1'b0;
        pc_sel_c   = SEL_SEQ;
        dcnt_nxt   = dcnt;
        freeze     = 1'b0;

        case (state)
            ST_DRAIN, ST_FREEZE: drain_step = (dcnt != '0);
            default:             drain_step = 1'b0;
        endcase

        if (bus.exc_req) begin
            flush_c  = EXC_MASK;
            pc_sel_c = SEL_EXC;
            dcnt_nxt = LAT_LOAD;
        end else if (bus.mem_busy) begin
            // Whole pipe holds; the drain counter waits for the freeze to end.
            stall_c    = '1;
            pc_stall_c = 1'b1;
            freeze     = 1'b1;
        end else if (bus.br_taken) begin
            flush_c  = BR_MASK;
            pc_sel_c = SEL_BR;
            dcnt_nxt = LAT_LOAD;
        end else if (bus.jump) begin
            flush_c  = J_MASK;
            pc_sel_c = SEL_JUMP;
            dcnt_nxt = LAT_LOAD;
        end else begin
            if (drain_step) begin
                flush_c[0] = 1'b1;
                dcnt_nxt   = dcnt - DW'(1);
            end
            if (bus.load_use) begin
                pc_stall_c = 1'b1;
                stall_c    = J_MASK;
                flush_c    = flush_c | BUBBLE_BIT;
            end
        end

        // During a drain reg 0 holds a wrong-path fetch, so clearing it wins
        // over the load-use hold on the same register.
        stall_c = stall_c & ~flush_c;

        if (freeze) begin
            state_nxt = ST_FREEZE;
        end else if (dcnt_nxt != '0) begin
            state_nxt = ST_DRAIN;
        end else begin
            state_nxt = ST_IDLE;
        end

        if (!rst_n) begin
            flush_c    = '0;
            stall_c    = '0;
            pc_stall_c = 1'b0;
            pc_sel_c   = SEL_SEQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    assign bus.flush      = flush_c;
    assign bus.stall      = stall_c;
    assign bus.pc_stall   = pc_stall_c;
    assign bus.pc_sel     = pc_sel_c;
    assign bus.drain_busy = (dcnt != '0);

`ifdef FLUSH_STATS_EN
    logic        redirect_acc;
    logic        bubble_acc;
    logic [15:0] redirect_q;
    logic [15:0] bubble_q;

    // Only the winning event is counted; a nonzero pc_sel marks a redirect.
    assign redirect_acc = (pc_sel_c != SEL_SEQ);
    assign bubble_acc   = bus.load_use && !bus.exc_req && !bus.mem_busy
                          && !bus.br_taken && !bus.jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q <= '0;
            bubble_q   <= '0;
        end else begin
            if (redirect_acc && (redirect_q != 16'hFFFF)) begin
                redirect_q <= redirect_q + 16'd1;
            end
            if (bubble_acc && (bubble_q != 16'hFFFF)) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

    assign bus.redirect_cnt = redirect_q;
    assign bus.bubble_cnt   = bubble_q;
`else
    assign bus.redirect_cnt = 16'd0;
    assign bus.bubble_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb_pipe_flush_ctrl
// Scoreboard bench for pipe_flush_ctrl. Three instances share clock and
// reset: REDIRECT_LAT = 0, 2 and 3. Each directed vector drives one instance
// and queues its hand-computed expected outputs; a monitor on the falling
// edge pops and compares.
module tb_pipe_flush_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_flush_ctrl_if #(.STAGES(5)) bus0 ();
    pipe_flush_ctrl_if #(.STAGES(5)) bus1 ();
    pipe_flush_ctrl_if #(.STAGES(5)) bus2 ();

    pipe_flush_ctrl #(.REDIRECT_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    pipe_flush_ctrl #(.REDIRECT_LAT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    pipe_flush_ctrl #(.REDIRECT_LAT(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    typedef struct {
        int          dut;
        string       name;
        logic [3:0]  flush;
        logic [3:0]  stall;
        logic        pc_stall;
        logic [1:0]  pc_sel;
        logic        drain_busy;
        logic [15:0] redirect_cnt;
        logic [15:0] bubble_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vec_count  = 0;
    int   miss_count = 0;
    int   m_redir[3];
    int   m_bub[3];

    task automatic clearInputs();
        bus0.jump = 0; bus0.br_taken = 0; bus0.exc_req = 0; bus0.load_use = 0; bus0.mem_busy = 0;
        bus1.jump = 0; bus1.br_taken = 0; bus1.exc_req = 0; bus1.load_use = 0; bus1.mem_busy = 0;
        bus2.jump = 0; bus2.br_taken = 0; bus2.exc_req = 0; bus2.load_use = 0; bus2.mem_busy = 0;
    endtask

    // Drives one cycle on instance d and queues the expected response.
    task automatic applyStimulus(input int d, input logic r, input logic j, input logic b,
                                 input logic e, input logic lu, input logic mb,
                                 input logic [3:0] ef, input logic [3:0] es, input logic eps,
                                 input logic [1:0] esel, input logic edb, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r;
        clearInputs();
        case (d)
            0: begin bus0.jump = j; bus0.br_taken = b; bus0.exc_req = e; bus0.load_use = lu; bus0.mem_busy = mb; end
            1: begin bus1.jump = j; bus1.br_taken = b; bus1.exc_req = e; bus1.load_use = lu; bus1.mem_busy = mb; end
            default: begin bus2.jump = j; bus2.br_taken = b; bus2.exc_req = e; bus2.load_use = lu; bus2.mem_busy = mb; end
        endcase
        if (!r) begin
            for (int k = 0; k < 3; k++) begin
                m_redir[k] = 0;
                m_bub[k]   = 0;
            end
        end
        x.dut          = d;
        x.name         = nm;
        x.flush        = ef;
        x.stall        = es;
        x.pc_stall     = eps;
        x.pc_sel       = esel;
        x.drain_busy   = edb;
        x.redirect_cnt = 16'(m_redir[d]);
        x.bubble_cnt   = 16'(m_bub[d]);
        exp_q.push_back(x);
`ifdef FLUSH_STATS_EN
        if (r) begin
            if (e || (!mb && (b || j))) m_redir[d]++;
            else if (!mb && lu) m_bub[d]++;
        end
`endif
    endtask

    task automatic checkOutput(input exp_t x);
        logic [3:0]  a_flush, a_stall;
        logic        a_ps, a_db;
        logic [1:0]  a_sel;
        logic [15:0] a_rc, a_bc;
        case (x.dut)
            0: begin a_flush = bus0.flush; a_stall = bus0.stall; a_ps = bus0.pc_stall; a_sel = bus0.pc_sel;
                     a_db = bus0.drain_busy; a_rc = bus0.redirect_cnt; a_bc = bus0.bubble_cnt; end
            1: begin a_flush = bus1.flush; a_stall = bus1.stall; a_ps = bus1.pc_stall; a_sel = bus1.pc_sel;
                     a_db = bus1.drain_busy; a_rc = bus1.redirect_cnt; a_bc = bus1.bubble_cnt; end
            default: begin a_flush = bus2.flush; a_stall = bus2.stall; a_ps = bus2.pc_stall; a_sel = bus2.pc_sel;
                     a_db = bus2.drain_busy; a_rc = bus2.redirect_cnt; a_bc = bus2.bubble_cnt; end
        endcase
        vec_count++;
        if (a_flush !== x.flush || a_stall !== x.stall || a_ps !== x.pc_stall || a_sel !== x.pc_sel ||
            a_db !== x.drain_busy || a_rc !== x.redirect_cnt || a_bc !== x.bubble_cnt) begin
            miss_count++;
            $display("[TB] FAIL %s (dut%0d): got flush=%b stall=%b pc_stall=%b pc_sel=%0d drain=%b rc=%0d bc=%0d, want flush=%b stall=%b pc_stall=%b pc_sel=%0d drain=%b rc=%0d bc=%0d",
                     x.name, x.dut, a_flush, a_stall, a_ps, a_sel, a_db, a_rc, a_bc,
                     x.flush, x.stall, x.pc_stall, x.pc_sel, x.drain_busy, x.redirect_cnt, x.bubble_cnt);
        end
    endtask

    // Monitor: compares every queued expectation mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                checkOutput(x);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        //            d  r  j  b  e  lu mb  flush    stall    ps  sel   db
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "reset1");
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "reset2");

        // REDIRECT_LAT = 0
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 4'b0011, 4'b0000, 0, 2'd2, 0, "br_taken");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "br_after");
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 4'b0000, 4'b1111, 1, 2'd0, 0, "freeze1");
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 4'b0000, 4'b1111, 1, 2'd0, 0, "freeze2");
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 4'b0000, 4'b1111, 1, 2'd0, 0, "freeze3");
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 4'b0011, 4'b0000, 0, 2'd2, 0, "freeze_exit");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "idle_a");
        applyStimulus(0, 1, 0, 1, 1, 1, 0, 4'b1111, 4'b0000, 0, 2'd3, 0, "exc_prio");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "idle_b");
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 4'b0010, 4'b0001, 1, 2'd0, 0, "load_use");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "after_lu");
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 4'b0011, 4'b0000, 0, 2'd2, 0, "br_over_jump");
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 4'b1111, 4'b0000, 0, 2'd3, 0, "exc_over_mem");
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd1, 0, "jump");
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 4'b0000, 4'b1111, 1, 2'd0, 0, "mem_over_lu");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "idle_c");

        // REDIRECT_LAT = 2
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd1, 0, "lat2_jump");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat2_drain1");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat2_drain2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "lat2_done");
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd1, 0, "lat2_jump_b");
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 4'b0011, 4'b0000, 1, 2'd0, 1, "lat2_lu_drain");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat2_lu_tail");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "lat2_lu_done");
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd1, 0, "lat2_jump_c");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat2_pre_frz");
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 2'd0, 1, "lat2_frz1");
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 2'd0, 1, "lat2_frz2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat2_frz_exit");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "lat2_frz_done");

        // REDIRECT_LAT = 3: reload on a redirect inside the drain
        applyStimulus(2, 1, 0, 1, 0, 0, 0, 4'b0011, 4'b0000, 0, 2'd2, 0, "lat3_br");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat3_drain");
        applyStimulus(2, 1, 1, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd1, 1, "lat3_jump");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat3_reload1");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat3_reload2");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat3_reload3");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "lat3_done");
        applyStimulus(2, 1, 0, 1, 0, 0, 0, 4'b0011, 4'b0000, 0, 2'd2, 0, "lat3_br_b");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 2'd0, 1, "lat3_drain_b");
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "lat3_async_rst");
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "lat3_post_rst");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, "dut0_post_rst");

        @(posedge clk);
        #1;
        clearInputs();
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miss_count++;
            $display("[TB] FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
